// File: rtl/misc_exec_if.sv
// Issue-side and commit-side bus of the branch/CSR execution pipe.
// MISC_PIPE_DIFF_EN adds out_pc_o / out_csr_rdata_o for difftest tracing.
interface misc_exec_if #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 6,
  parameter int PREG_W    = 6
);
  logic                 flush_i;
  logic                 kill_valid_i;
  logic [ROB_IDX_W-1:0] kill_rob_idx_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [3:0]           in_op_i;
  logic [XLEN-1:0]      in_pc_i;
  logic [XLEN-1:0]      in_imm_i;
  logic [XLEN-1:0]      in_src0_i;
  logic [XLEN-1:0]      in_src1_i;
  logic                 in_link_i;
  logic                 in_pred_taken_i;
  logic [XLEN-1:0]      in_pred_target_i;
  logic [PREG_W-1:0]    in_pdest_i;
  logic [ROB_IDX_W-1:0] in_rob_idx_i;
  logic [XLEN-1:0]      csr_rdata_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_we_o;
  logic [XLEN-1:0]      out_wdata_o;
  logic [PREG_W-1:0]    out_pdest_o;
  logic [ROB_IDX_W-1:0] out_rob_idx_o;
  logic                 out_br_taken_o;
  logic                 out_redirect_o;
  logic [XLEN-1:0]      out_br_target_o;
  logic                 out_csr_we_o;
  logic [13:0]          out_csr_waddr_o;
  logic [XLEN-1:0]      out_csr_wdata_o;
`ifdef MISC_PIPE_DIFF_EN
  logic [XLEN-1:0]      out_pc_o;
  logic [XLEN-1:0]      out_csr_rdata_o;
`endif

  modport master (
`ifdef MISC_PIPE_DIFF_EN
    input  out_pc_o, out_csr_rdata_o,
`endif
    output flush_i, kill_valid_i, kill_rob_idx_i, in_valid_i, in_op_i, in_pc_i,
           in_imm_i, in_src0_i, in_src1_i, in_link_i, in_pred_taken_i,
           in_pred_target_i, in_pdest_i, in_rob_idx_i, csr_rdata_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_we_o, out_wdata_o, out_pdest_o,
           out_rob_idx_o, out_br_taken_o, out_redirect_o, out_br_target_o,
           out_csr_we_o, out_csr_waddr_o, out_csr_wdata_o
  );

  modport slave (
`ifdef MISC_PIPE_DIFF_EN
    output out_pc_o, out_csr_rdata_o,
`endif
    input  flush_i, kill_valid_i, kill_rob_idx_i, in_valid_i, in_op_i, in_pc_i,
           in_imm_i, in_src0_i, in_src1_i, in_link_i, in_pred_taken_i,
           in_pred_target_i, in_pdest_i, in_rob_idx_i, csr_rdata_i, out_ready_i,
    output in_ready_o, out_valid_o, out_we_o, out_wdata_o, out_pdest_o,
           out_rob_idx_o, out_br_taken_o, out_redirect_o, out_br_target_o,
           out_csr_we_o, out_csr_waddr_o, out_csr_wdata_o
  );
endinterface

// File: rtl/misc_exec_pipe.sv
// Branch/CSR execution pipe: resolve at entry, then DEPTH elastic register stages
// with flush and ROB-age selective kill. MISC_PIPE_DIFF_EN carries pc/csr_rdata too.
module misc_exec_pipe #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 6,
  parameter int PREG_W    = 6,
  parameter int DEPTH     = 2
) (
  input logic     clk,
  input logic     rst_n,
  misc_exec_if.slave bus
);
  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      wdata;
    logic [PREG_W-1:0]    pdest;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 br_taken;
    logic                 redirect;
    logic [XLEN-1:0]      br_target;
    logic                 csr_we;
    logic [13:0]          csr_waddr;
    logic [XLEN-1:0]      csr_wdata;
`ifdef MISC_PIPE_DIFF_EN
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      csr_rdata;
`endif
  } pl_t;

  // MSB is the phase bit: a differing phase inverts the magnitude compare.
  function automatic logic younger(input logic [ROB_IDX_W-1:0] e, input logic [ROB_IDX_W-1:0] k);
    return (e[ROB_IDX_W-2:0] > k[ROB_IDX_W-2:0]) ^ (e[ROB_IDX_W-1] != k[ROB_IDX_W-1]);
  endfunction

  pl_t             cur;
  logic            taken;
  logic [XLEN-1:0] pc4, tgt;
  logic [3:0]      op;

  assign op  = bus.in_op_i;
  assign pc4 = bus.in_pc_i + XLEN'(4);
  assign tgt = (op == 4'd6) ? bus.in_src0_i + bus.in_imm_i : bus.in_pc_i + bus.in_imm_i;

  always_comb begin
    cur   = '0;
    taken = 1'b0;
    case (op)
      4'd0:       taken = bus.in_src0_i == bus.in_src1_i;
      4'd1:       taken = bus.in_src0_i != bus.in_src1_i;
      4'd2:       taken = $signed(bus.in_src0_i) <  $signed(bus.in_src1_i);
      4'd3:       taken = $signed(bus.in_src0_i) >= $signed(bus.in_src1_i);
      4'd4:       taken = bus.in_src0_i <  bus.in_src1_i;
      4'd5:       taken = bus.in_src0_i >= bus.in_src1_i;
      4'd6, 4'd7: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
    cur.pdest   = bus.in_pdest_i;
    cur.rob_idx = bus.in_rob_idx_i;
    if (op <= 4'd7) begin
      cur.br_taken  = taken;
      cur.br_target = taken ? tgt : pc4;
      cur.redirect  = (taken != bus.in_pred_taken_i) | (taken & (tgt != bus.in_pred_target_i));
      cur.we        = bus.in_link_i;
      cur.wdata     = pc4;
    end else if (op <= 4'd10) begin
      cur.we        = 1'b1;
      cur.wdata     = bus.csr_rdata_i;
      cur.csr_waddr = bus.in_imm_i[13:0];
      cur.csr_we    = op != 4'd8;
      cur.csr_wdata = (op == 4'd9) ? bus.in_src0_i
                    : (bus.in_src0_i & bus.in_src1_i) | (bus.csr_rdata_i & ~bus.in_src1_i);
    end
`ifdef MISC_PIPE_DIFF_EN
    cur.pc        = bus.in_pc_i;
    cur.csr_rdata = bus.csr_rdata_i;
`endif
  end

  logic [DEPTH-1:0] vld_pipe, adv, src_vld;
  pl_t              pl     [DEPTH];
  pl_t              src_pl [DEPTH];
  logic             full;

  // A stage stalls only when it and every stage downstream are full and the sink is stalled.
  always_comb begin
    adv     = '0;
    src_vld = '0;
    full    = 1'b1;
    for (int k = DEPTH-1; k >= 0; k--) begin
      full   = full & vld_pipe[k];
      adv[k] = bus.out_ready_i | ~full;
    end
    src_vld[0] = bus.in_valid_i;
    src_pl[0]  = cur;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k] = vld_pipe[k-1];
      src_pl[k]  = pl[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < DEPTH; k++) pl[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.flush_i) begin
          vld_pipe[k] <= 1'b0;
        end else if (adv[k]) begin
          vld_pipe[k] <= src_vld[k] & ~(bus.kill_valid_i & younger(src_pl[k].rob_idx, bus.kill_rob_idx_i));
          if (src_vld[k]) pl[k] <= src_pl[k];
        end else begin
          vld_pipe[k] <= vld_pipe[k] & ~(bus.kill_valid_i & younger(pl[k].rob_idx, bus.kill_rob_idx_i));
        end
      end
    end
  end

  assign bus.in_ready_o      = adv[0];
  assign bus.out_valid_o     = vld_pipe[DEPTH-1];
  assign bus.out_we_o        = pl[DEPTH-1].we;
  assign bus.out_wdata_o     = pl[DEPTH-1].wdata;
  assign bus.out_pdest_o     = pl[DEPTH-1].pdest;
  assign bus.out_rob_idx_o   = pl[DEPTH-1].rob_idx;
  assign bus.out_br_taken_o  = pl[DEPTH-1].br_taken;
  assign bus.out_redirect_o  = pl[DEPTH-1].redirect;
  assign bus.out_br_target_o = pl[DEPTH-1].br_target;
  assign bus.out_csr_we_o    = pl[DEPTH-1].csr_we;
  assign bus.out_csr_waddr_o = pl[DEPTH-1].csr_waddr;
  assign bus.out_csr_wdata_o = pl[DEPTH-1].csr_wdata;
`ifdef MISC_PIPE_DIFF_EN
  assign bus.out_pc_o        = pl[DEPTH-1].pc;
  assign bus.out_csr_rdata_o = pl[DEPTH-1].csr_rdata;
`endif
endmodule
